// File: rtl/ssa_pkg.sv
// Shared configuration for the carry-resolve block: digit/coefficient geometry
// defaults and the frame-control state encoding.
package ssa_pkg;

    localparam int SSA_DW    = 2;
    localparam int SSA_NCOEF = 8;
    localparam int SSA_CW    = 6;
    localparam int SSA_PW    = SSA_NCOEF * SSA_DW;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } ssa_state_e;

endpackage

// File: rtl/ssa_carry_resolve_if.sv
// Coefficient-in / digit-and-product-out bundle for ssa_carry_resolve.
// The ovf wire exists only when SSA_CARRY_OVF_EN is defined.
interface ssa_carry_resolve_if import ssa_pkg::*; #(
    parameter int DW = SSA_DW,
    parameter int CW = SSA_CW,
    parameter int PW = SSA_PW
);
    logic [CW-1:0] coef;
    logic          coef_valid;
    logic          coef_ready;
    logic [DW-1:0] dig;
    logic          dig_valid;
    logic [PW-1:0] product;
    logic          prod_valid;
    logic          prod_ready;
`ifdef SSA_CARRY_OVF_EN
    logic          ovf;
`endif

    modport slave (
        input  coef, coef_valid, prod_ready,
        output coef_ready, dig, dig_valid, product, prod_valid
`ifdef SSA_CARRY_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output coef, coef_valid, prod_ready,
        input  coef_ready, dig, dig_valid, product, prod_valid
`ifdef SSA_CARRY_OVF_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/ssa_carry_resolve.sv
// Resolves a stream of wide convolution coefficients into radix-2^DW digits and
// assembles them into one product word per frame. Optional ovf via SSA_CARRY_OVF_EN.
module ssa_carry_resolve import ssa_pkg::*; #(
    parameter int DW    = SSA_DW,
    parameter int NCOEF = SSA_NCOEF,
    parameter int CW    = SSA_CW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    ssa_carry_resolve_if.slave bus
);

    localparam int PW = NCOEF * DW;
    localparam int KW = CW - DW + 1;
    localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

    ssa_state_e    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [KW-1:0] carry_q;
    logic [PW-1:0] product_q;
    logic [DW-1:0] dig_q;
    logic          dig_valid_q;
    logic          prod_valid_q;
    logic          accept;
    logic          last;
    logic          release_prod;
    logic [CW:0]   sum;

    // Full-width sum: the carry can exceed one digit when coefficients are wide.
    assign sum  = (CW+1)'(bus.coef) + (CW+1)'(carry_q);
    assign last = accept && (idx_q == LAST_IDX);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        release_prod = 1'b0;
        case (state_q)
            ST_ACC: begin
                accept = bus.coef_valid;
                if (accept && (idx_q == LAST_IDX)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                release_prod = bus.prod_ready;
                if (release_prod) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
        if (clear) state_d = ST_ACC;
    end

    // NOTE: registers use non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            carry_q      <= '0;
            product_q    <= '0;
            dig_q        <= '0;
            dig_valid_q  <= 1'b0;
            prod_valid_q <= 1'b0;
        end else if (clear) begin
            idx_q        <= '0;
            carry_q      <= '0;
            product_q    <= '0;
            dig_valid_q  <= 1'b0;
            prod_valid_q <= 1'b0;
        end else begin
            dig_valid_q <= accept;
            if (accept) begin
                dig_q                         <= sum[DW-1:0];
                carry_q                       <= sum[CW:DW];
                product_q[int'(idx_q)*DW +: DW] <= sum[DW-1:0];
                idx_q                         <= last ? '0 : idx_q + 1'b1;
                if (last) prod_valid_q <= 1'b1;
            end else if (release_prod) begin
                idx_q        <= '0;
                carry_q      <= '0;
                product_q    <= '0;
                prod_valid_q <= 1'b0;
            end
        end
    end

`ifdef SSA_CARRY_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ovf_q <= 1'b0;
        else if (clear)             ovf_q <= 1'b0;
        else if (last)              ovf_q <= |sum[CW:DW];
        else if (release_prod)      ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.coef_ready = (state_q == ST_ACC);
    assign bus.dig        = dig_q;
    assign bus.dig_valid  = dig_valid_q;
    assign bus.product    = product_q;
    assign bus.prod_valid = prod_valid_q;

endmodule
